// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an instruction class into an ALU operation, issues registered
// operands, captures the result one cycle later and returns it. Optional trap: ALU_ILLEGAL_TRAP_EN.
module alu_issue_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   input  logic [DATA_WIDTH-1:0]    opa,
   input  logic [DATA_WIDTH-1:0]    opb,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_result,
   output logic                     out_branch_taken
`ifdef ALU_ILLEGAL_TRAP_EN
   ,output logic                    out_illegal
`endif
);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = 'h0;
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 'h1;
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 'h2;
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 'h3;
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 'h4;
   localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 'h5;
   localparam logic [OPCODE_LENGTH-1:0] OP_LUI = 'h6;
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 'h7;
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 'h8;
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 'h9;
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 'hA;
   localparam logic [OPCODE_LENGTH-1:0] OP_LT  = 'hC;
   localparam logic [OPCODE_LENGTH-1:0] OP_JAL = 'hD;
   localparam logic [OPCODE_LENGTH-1:0] OP_GE  = 'hF;

`ifdef ALU_ILLEGAL_TRAP_EN
   localparam logic [OPCODE_LENGTH-1:0] OP_ILLEGAL = OP_AND;
`else
   localparam logic [OPCODE_LENGTH-1:0] OP_ILLEGAL = OP_ADD;
`endif

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t                   state_q, state_d;
   logic [OPCODE_LENGTH-1:0] dec_op;
   logic                     dec_inv;
   logic                     dec_ill;
   logic [1:0]               cls_q;
   logic                     inv_q;
   logic                     alt_f7;

   assign alt_f7 = (Funct7 == 7'b0100000);

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      dec_op  = OP_ADD;
      dec_inv = 1'b0;
      dec_ill = 1'b0;
      case (ALUOp)
         2'b00: dec_op = OP_ADD;
         2'b01: begin
            case (Funct3)
               3'b000:  dec_op = OP_EQ;
               3'b001:  begin dec_op = OP_EQ; dec_inv = 1'b1; end  // BNE: inverted EQ, never XOR
               3'b100:  dec_op = OP_LT;
               3'b101:  dec_op = OP_GE;
               default: dec_ill = 1'b1;
            endcase
         end
         2'b10: begin
            case (Funct3)
               3'b000:  dec_op = alt_f7 ? OP_SUB : OP_ADD;
               3'b111:  dec_op = OP_AND;
               3'b110:  dec_op = OP_OR;
               3'b100:  dec_op = OP_XOR;
               3'b010:  dec_op = OP_SLT;
               3'b001:  dec_op = OP_SLL;
               3'b101:  dec_op = alt_f7 ? OP_SRA : OP_SRL;
               default: dec_ill = 1'b1;
            endcase
         end
         default: begin
            case (Funct3)
               3'b000:  dec_op = OP_JAL;
               3'b001:  dec_op = OP_LUI;
               default: dec_ill = 1'b1;
            endcase
         end
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

`ifdef ALU_ILLEGAL_TRAP_EN
   logic ill_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Operation        <= '0;
         SrcA             <= '0;
         SrcB             <= '0;
         out_result       <= '0;
         out_branch_taken <= 1'b0;
         cls_q            <= 2'b00;
         inv_q            <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
         ill_q            <= 1'b0;
         out_illegal      <= 1'b0;
`endif
      end else begin
         if (state_q == IDLE && in_valid) begin
            Operation <= dec_ill ? OP_ILLEGAL : dec_op;
            SrcA      <= opa;
            SrcB      <= opb;
            cls_q     <= ALUOp;
            inv_q     <= dec_inv;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_q     <= dec_ill;
`endif
         end
         // Capture at the end of the settle cycle; held through DONE until consumed.
         if (state_q == EXEC) begin
            out_result       <= ALUResult ^ {{(DATA_WIDTH-1){1'b0}}, inv_q};
            out_branch_taken <= (cls_q == 2'b01) ? (ALUResult[0] ^ inv_q) : 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
            out_illegal      <= ill_q;
            if (ill_q) begin
               out_result       <= '0;
               out_branch_taken <= 1'b0;
            end
`endif
         end
      end
   end

endmodule
